// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of the combinational program ROM: fetch vs. load, 2-stage tagged pipeline.
// Optional macro ROM_ARB_FAIR_EN adds a load starvation counter that forces a load win after STARVE_MAX losses.
module rom_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  input  logic              if_flush,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_LD   = 2'd2
  } tag_e;

  tag_e              s1_tag_q, s1_tag_d;
  tag_e              s2_tag_q, s2_tag_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              ld_force;

`ifdef ROM_ARB_FAIR_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign ld_force = (starve_q == CNT_W'(STARVE_MAX));

  // Counts conflict cycles the load port lost; saturates at STARVE_MAX.
  always_comb begin
    starve_d = starve_q;
    if (!ld_req || ld_gnt) begin
      starve_d = '0;
    end else if (if_gnt && !ld_force) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign ld_force = 1'b0;
`endif

  assign ld_gnt = ld_req && (!if_req || ld_force);
  assign if_gnt = if_req && !ld_gnt;

  always_comb begin
    s1_tag_d   = TAG_NONE;
    rom_addr_d = rom_addr_q;
    if (if_gnt) begin
      s1_tag_d   = TAG_IF;
      rom_addr_d = if_addr;
    end else if (ld_gnt) begin
      s1_tag_d   = TAG_LD;
      rom_addr_d = ld_addr;
    end
  end

  // A flush kills the fetch sitting in S1 as it moves into S2; the one already in S2 is masked at the output.
  always_comb begin
    s2_tag_d   = s1_tag_q;
    if_rdata_d = if_rdata_q;
    ld_rdata_d = ld_rdata_q;
    if (if_flush && s1_tag_q == TAG_IF) begin
      s2_tag_d = TAG_NONE;
    end
    if (s2_tag_d == TAG_IF) begin
      if_rdata_d = rom_dout;
    end
    if (s2_tag_d == TAG_LD) begin
      ld_rdata_d = rom_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_tag_q   <= TAG_NONE;
      s2_tag_q   <= TAG_NONE;
      rom_addr_q <= '0;
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
    end else begin
      s1_tag_q   <= s1_tag_d;
      s2_tag_q   <= s2_tag_d;
      rom_addr_q <= rom_addr_d;
      if_rdata_q <= if_rdata_d;
      ld_rdata_q <= ld_rdata_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign if_rdata  = if_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign if_rvalid = (s2_tag_q == TAG_IF) && !if_flush;
  assign ld_rvalid = (s2_tag_q == TAG_LD);
  assign busy      = (s1_tag_q != TAG_NONE) || (s2_tag_q != TAG_NONE);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter; ROM model returns 16'hC000 | addr.
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, ld_req;
  logic [9:0]  if_addr, ld_addr, rom_addr;
  logic        if_gnt, if_rvalid, ld_gnt, ld_rvalid, busy;
  logic [15:0] if_rdata, ld_rdata, rom_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_dout = 16'hC000 | {6'd0, rom_addr};

  rom_port_arbiter #(.ADDR_W(10), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .busy(busy)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 0; ld_req = 0; if_flush = 0; if_addr = '0; ld_addr = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (rom_addr !== 10'h000) begin errors++; $display("FAIL reset_rom_addr got %h exp 000", rom_addr); end
    checks++; if ({if_rvalid, ld_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", {if_rvalid, ld_rvalid}); end
    checks++; if ({if_rdata, ld_rdata} !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {if_rdata, ld_rdata}); end
    tick; rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_fetch;
    tick; if_req = 1; if_addr = 10'h002;
    @(negedge clk);
    checks++; if ({if_gnt, ld_gnt} !== 2'b10) begin errors++; $display("FAIL single_gnt got %b exp 10", {if_gnt, ld_gnt}); end
    tick; if_req = 0;
    @(negedge clk);
    checks++; if (rom_addr !== 10'h002) begin errors++; $display("FAIL single_rom_addr got %h exp 002", rom_addr); end
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL single_early_rvalid got %b exp 0", if_rvalid); end
    tick;
    @(negedge clk);
    checks++; if ({if_rvalid, ld_rvalid} !== 2'b10) begin errors++; $display("FAIL single_rvalid got %b exp 10", {if_rvalid, ld_rvalid}); end
    checks++; if (if_rdata !== 16'hC002) begin errors++; $display("FAIL single_rdata got %h exp C002", if_rdata); end
    tick;
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", if_rvalid); end
    $display("test_single_fetch addr 002 data %h", if_rdata);
  endtask

  task automatic test_conflict;
    tick; if_req = 1; if_addr = 10'h004; ld_req = 1; ld_addr = 10'h006;
    @(negedge clk);
    checks++; if ({if_gnt, ld_gnt} !== 2'b10) begin errors++; $display("FAIL conflict_gnt1 got %b exp 10", {if_gnt, ld_gnt}); end
    tick; if_req = 0;
    @(negedge clk);
    checks++; if ({if_gnt, ld_gnt} !== 2'b01) begin errors++; $display("FAIL conflict_gnt2 got %b exp 01", {if_gnt, ld_gnt}); end
    tick; ld_req = 0;
    @(negedge clk);
    checks++; if ({if_rvalid, ld_rvalid} !== 2'b10) begin errors++; $display("FAIL conflict_rv1 got %b exp 10", {if_rvalid, ld_rvalid}); end
    checks++; if (if_rdata !== 16'hC004) begin errors++; $display("FAIL conflict_if_rdata got %h exp C004", if_rdata); end
    tick;
    @(negedge clk);
    checks++; if ({if_rvalid, ld_rvalid} !== 2'b01) begin errors++; $display("FAIL conflict_rv2 got %b exp 01", {if_rvalid, ld_rvalid}); end
    checks++; if (ld_rdata !== 16'hC006) begin errors++; $display("FAIL conflict_ld_rdata got %h exp C006", ld_rdata); end
    checks++; if (if_rdata !== 16'hC004) begin errors++; $display("FAIL conflict_if_hold got %h exp C004", if_rdata); end
    $display("test_conflict if %h ld %h", if_rdata, ld_rdata);
  endtask

  task automatic test_fairness;
    int ld_wins = 0;
    tick; if_req = 1; if_addr = 10'h010; ld_req = 1; ld_addr = 10'h020;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ld_gnt === 1'b1) ld_wins++;
`ifdef ROM_ARB_FAIR_EN
      checks++;
      if (ld_gnt !== ((c % 5) == 4)) begin
        errors++; $display("FAIL fair_ld_gnt cycle %0d got %b exp %b", c, ld_gnt, ((c % 5) == 4));
      end
`endif
      tick;
    end
`ifdef ROM_ARB_FAIR_EN
    checks++; if (ld_wins !== 3) begin errors++; $display("FAIL fair_count got %0d exp 3", ld_wins); end
`else
    checks++; if (ld_wins !== 0) begin errors++; $display("FAIL strict_count got %0d exp 0", ld_wins); end
`endif
    if_req = 0; ld_req = 0;
    tick; tick; tick;
    $display("test_fairness load wins %0d in 15 cycles", ld_wins);
  endtask

  task automatic test_flush;
    tick; if_req = 1; if_addr = 10'h005;
    @(negedge clk);
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_gnt5 got %b exp 1", if_gnt); end
    tick; if_addr = 10'h006;
    @(negedge clk);
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_gnt6 got %b exp 1", if_gnt); end
    tick; if_req = 0; if_flush = 1; ld_req = 1; ld_addr = 10'h001;
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL flush_rv5 got %b exp 0", if_rvalid); end
    checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL flush_ld_gnt got %b exp 1", ld_gnt); end
    tick; if_flush = 0; ld_req = 0;
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL flush_rv6 got %b exp 0", if_rvalid); end
    tick;
    @(negedge clk);
    checks++; if ({if_rvalid, ld_rvalid} !== 2'b01) begin errors++; $display("FAIL flush_ld_rv got %b exp 01", {if_rvalid, ld_rvalid}); end
    checks++; if (ld_rdata !== 16'hC001) begin errors++; $display("FAIL flush_ld_rdata got %h exp C001", ld_rdata); end
    tick;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_drain got %b exp 0", busy); end
    $display("test_flush load data %h", ld_rdata);
  endtask

  task automatic test_reset_midflight;
    tick; if_req = 1; if_addr = 10'h007;
    tick; if_req = 0;
    rst = 1'b1;
    #1;
    checks++; if ({if_rvalid, ld_rvalid, busy} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags got %b exp 000", {if_rvalid, ld_rvalid, busy}); end
    checks++; if (rom_addr !== 10'h000) begin errors++; $display("FAIL mid_rst_rom_addr got %h exp 000", rom_addr); end
    checks++; if (if_rdata !== 16'h0000) begin errors++; $display("FAIL mid_rst_rdata got %h exp 0000", if_rdata); end
    tick; rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({if_rvalid, ld_rvalid} !== 2'b00) begin
        errors++; $display("FAIL mid_rst_stale cycle %0d got %b exp 00", c, {if_rvalid, ld_rvalid});
      end
      tick;
    end
    $display("test_reset_midflight done");
  endtask

  task automatic test_idle;
    tick; ld_req = 1; ld_addr = 10'h3FF;
    @(negedge clk);
    checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL idle_gnt got %b exp 1", ld_gnt); end
    tick; ld_req = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idle_busy1 got %b exp 1", busy); end
    tick;
    @(negedge clk);
    checks++; if (ld_rdata !== 16'hC3FF) begin errors++; $display("FAIL idle_wrap_rdata got %h exp C3FF", ld_rdata); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idle_busy2 got %b exp 1", busy); end
    tick;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy3 got %b exp 0", busy); end
    tick; tick;
    @(negedge clk);
    checks++; if (ld_rdata !== 16'hC3FF) begin errors++; $display("FAIL idle_hold got %h exp C3FF", ld_rdata); end
    checks++; if (ld_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid got %b exp 0", ld_rvalid); end
    $display("test_idle wrap data %h", ld_rdata);
  endtask

  initial begin
    test_reset;
    test_single_fetch;
    test_conflict;
    test_fairness;
    test_flush;
    test_reset_midflight;
    test_idle;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
